// File: rtl/collatz_sync_core_pkg.sv
// collatz_sync_core_pkg: state encoding and error sentinel shared by the Collatz core
package collatz_sync_core_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam logic [63:0] ERR_ALL = '1;
endpackage

// File: rtl/collatz_sync_core_step.sv
// collatz_step: one combinational Collatz step with terminal and overflow flags
module collatz_step #(
  parameter int N = 27
) (
  input  logic [N-1:0] n,
  output logic [N-1:0] next,
  output logic         is_one,
  output logic         is_zero,
  output logic         ovf
);
  logic [N+1:0] t;
  // 3n+1 is formed as n + 2n + 1 at N+2 bits so it is never truncated
  assign t       = {2'b00, n} + {1'b0, n, 1'b0} + (N+2)'(1);
  assign next    = n[0] ? t[N-1:0] : n >> 1;
  assign is_one  = n == N'(1);
  assign is_zero = n == '0;
  assign ovf     = n[0] && |t[N+1:N];
endmodule

// File: rtl/collatz_sync_core.sv
// collatz_sync_core: valid/ready responder returning the Collatz step count of in0
import collatz_sync_core_pkg::*;
module collatz_sync_core #(
  parameter int N         = 27,
  parameter int MAX_STEPS = 2**N - 2
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in0,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out0,
  output logic         out_err
);
  localparam logic [N-1:0] LIMIT = N'(MAX_STEPS);
  localparam logic [N-1:0] ERR   = ERR_ALL[N-1:0];
  state_t       state;
  logic [N-1:0] n, steps, next;
  logic         is_one, is_zero, ovf;
  collatz_step #(.N(N)) u_step (.n(n), .next(next), .is_one(is_one), .is_zero(is_zero), .ovf(ovf));
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out0      <= '0;
      out_err   <= 1'b0;
      n         <= '0;
      steps     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            n        <= in0;
            steps    <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end else in_ready <= 1'b1;
        end
        RUN: begin
          // terminal checks win over stepping: zero, one, timeout, overflow
          if (is_zero || is_one || steps == LIMIT || ovf) begin
            out0      <= (!is_zero && is_one) ? steps : ERR;
            out_err   <= is_zero || !is_one;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            n     <= next;
            steps <= steps + N'(1);
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_collatz_sync_core.sv
// tb_collatz_sync_core: table-driven and scoreboarded checks of three core configurations
module tb_collatz_sync_core;
  logic        clk = 1'b0, nrst = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [26:0] in0 = '0;
  int          sel = 0;
  logic        r0, r1, r2, v0, v1, v2, e0, e1, e2;
  logic [26:0] o0, o1;
  logic [7:0]  o2;
  logic        rdy, ov, oe;
  logic [26:0] oo;
  int          checks = 0, errors = 0;

  typedef struct {int s; logic [26:0] n; logic [26:0] o; logic e; int lat;} vec_t;
  typedef struct {logic [26:0] o; logic e; int lat;} exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  collatz_sync_core u_main (.clk(clk), .nrst(nrst), .in_valid(in_valid && sel == 0), .in_ready(r0),
    .in0(in0), .out_valid(v0), .out_ready(out_ready), .out0(o0), .out_err(e0));
  collatz_sync_core #(.N(27), .MAX_STEPS(100)) u_lim (.clk(clk), .nrst(nrst), .in_valid(in_valid && sel == 1),
    .in_ready(r1), .in0(in0), .out_valid(v1), .out_ready(out_ready), .out0(o1), .out_err(e1));
  collatz_sync_core #(.N(8)) u_n8 (.clk(clk), .nrst(nrst), .in_valid(in_valid && sel == 2), .in_ready(r2),
    .in0(in0[7:0]), .out_valid(v2), .out_ready(out_ready), .out0(o2), .out_err(e2));

  assign rdy = sel == 0 ? r0 : sel == 1 ? r1 : r2;
  assign ov  = sel == 0 ? v0 : sel == 1 ? v1 : v2;
  assign oe  = sel == 0 ? e0 : sel == 1 ? e1 : e2;
  assign oo  = sel == 0 ? o0 : sel == 1 ? o1 : {19'd0, o2};

  task automatic chk(input string name, input logic [26:0] act, input logic [26:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // drive one value; the expectation goes to the scoreboard and is checked when out_valid appears
  task automatic send(input int s, input logic [26:0] n, input logic [26:0] o, input logic e, input int lat);
    exp_t x;
    int k;
    bit got;
    sel = s;
    in0 = n;
    in_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = rdy;
    end
    if (!got) begin
      chk("in_ready_timeout", 27'(rdy), 27'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    q.push_back('{o: o, e: e, lat: lat});
    got = 0;
    k = 0;
    while (!got && k < 300) begin
      @(posedge clk);
      #1 k++;
      got = ov;
    end
    x = q.pop_front();
    if (!got) begin
      chk("out_valid_timeout", 27'(ov), 27'd1);
      return;
    end
    chk($sformatf("lat s%0d n%0d", s, n), 27'(k), 27'(x.lat));
    chk($sformatf("out0 s%0d n%0d", s, n), oo, x.o);
    chk($sformatf("err s%0d n%0d", s, n), 27'(oe), 27'(x.e));
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1 chk("consume_valid", 27'(ov), 27'd0);
    chk("consume_ready", 27'(rdy), 27'd1);
  endtask

  vec_t tbl[$];
  logic saw;

  initial begin
    tbl = '{
      '{0, 27'd6,   27'd8,   1'b0, 9},
      '{0, 27'd27,  27'd111, 1'b0, 112},
      '{0, 27'd3,   27'd7,   1'b0, 8},
      '{0, 27'd2,   27'd1,   1'b0, 2},
      '{0, 27'd0,   '1,      1'b1, 1},
      '{0, '1,      '1,      1'b1, 1},
      '{1, 27'd27,  '1,      1'b1, 101},
      '{1, 27'd6,   27'd8,   1'b0, 9},
      '{2, 27'd255, 27'hFF,  1'b1, 1},
      '{2, 27'd0,   27'hFF,  1'b1, 1},
      '{2, 27'd7,   27'd16,  1'b0, 17}
    };
    // reset state, then release with a value already offered
    in_valid = 1'b1;
    in0 = 27'd1;
    #12;
    chk("rst_ready", 27'(r0), 27'd0);
    chk("rst_valid", 27'(v0), 27'd0);
    chk("rst_out0", o0, 27'd0);
    chk("rst_err", 27'(e0), 27'd0);
    @(negedge clk) nrst = 1'b1;
    @(posedge clk);
    #1 chk("ready_edge1", 27'(r0), 27'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("accepted_ready", 27'(r0), 27'd0);
    chk("one_not_yet", 27'(v0), 27'd0);
    @(posedge clk);
    #1 chk("one_valid", 27'(v0), 27'd1);
    chk("one_out0", o0, 27'd0);
    chk("one_err", 27'(e0), 27'd0);
    consume();

    foreach (tbl[i]) begin
      send(tbl[i].s, tbl[i].n, tbl[i].o, tbl[i].e, tbl[i].lat);
      consume();
    end

    // backpressure: result held, extra offers ignored
    out_ready = 1'b0;
    send(0, 27'd7, 27'd16, 1'b0, 17);
    for (int i = 0; i < 20; i++) begin
      in_valid = (i % 3 == 0);
      in0 = 27'd5;
      @(posedge clk);
      #1 chk("hold_valid", 27'(v0), 27'd1);
      chk("hold_out0", o0, 27'd16);
      chk("hold_err", 27'(e0), 27'd0);
      chk("hold_ready", 27'(r0), 27'd0);
    end
    in_valid = 1'b0;
    consume();
    @(posedge clk);
    #1 chk("no_second_result", 27'(v0), 27'd0);
    chk("idle_ready", 27'(r0), 27'd1);

    // reset mid-run discards the job
    sel = 0;
    in0 = 27'd27;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) nrst = 1'b0;
    #1 chk("midrst_ready", 27'(r0), 27'd0);
    chk("midrst_valid", 27'(v0), 27'd0);
    chk("midrst_out0", o0, 27'd0);
    chk("midrst_err", 27'(e0), 27'd0);
    #3 nrst = 1'b1;
    saw = 1'b0;
    repeat (130) begin
      @(posedge clk);
      #1 saw = saw | v0;
    end
    chk("midrst_no_pulse", 27'(saw), 27'd0);
    send(0, 27'd6, 27'd8, 1'b0, 9);
    consume();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
